// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: streams N raster frames from a 1-cycle-latency frame store to the VO front end,
// gating each frame on ready, with stall, line blanking and abort.
module frame_stream_ctrl #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int PIXEL_W    = 8,
  parameter int MAX_FRAMES = 4,
  parameter int LINE_GAP   = 0,
  parameter int ADDR_W     = $clog2(MAX_FRAMES*WIDTH*HEIGHT),
  parameter int FC_W       = $clog2(MAX_FRAMES+1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_go,
  input  logic [FC_W-1:0]    i_num_frames,
  input  logic               i_abort,
  input  logic               i_ready,
  input  logic               i_stall,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic               o_mem_re,
  input  logic [PIXEL_W-1:0] i_mem_data,
  output logic [PIXEL_W-1:0] o_pixel,
  output logic               o_valid,
  output logic               o_start,
  output logic               o_last,
  output logic [FC_W-1:0]    o_frame_idx,
  output logic               o_busy,
  output logic               o_done
);
  localparam int XW = $clog2(WIDTH+1);
  localparam int YW = $clog2(HEIGHT+1);
  localparam int GW = $clog2(LINE_GAP+2);
  typedef enum logic [2:0] {IDLE, WAIT_RDY, STREAM, GAP, DRAIN} state_t;
  state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_W-1:0] addr;
  logic [FC_W-1:0] num, nf;
  logic [GW-1:0] gcnt;
  logic v1, s1, l1, re, last_x, last_y, more;
  assign re = state == STREAM && !i_stall && !i_abort;
  assign last_x = x == XW'(WIDTH-1);
  assign last_y = y == YW'(HEIGHT-1);
  assign more = (o_frame_idx + FC_W'(1)) < num;
  assign nf = i_num_frames > FC_W'(MAX_FRAMES) ? FC_W'(MAX_FRAMES) : i_num_frames;
  assign o_mem_re = re;
  assign o_mem_addr = addr;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE; x <= '0; y <= '0; addr <= '0; num <= '0; gcnt <= '0;
      v1 <= 1'b0; s1 <= 1'b0; l1 <= 1'b0; o_pixel <= '0; o_valid <= 1'b0;
      o_start <= 1'b0; o_last <= 1'b0; o_frame_idx <= '0; o_done <= 1'b0;
    end else if (i_abort) begin
      state <= IDLE; x <= '0; y <= '0; addr <= '0; num <= '0; gcnt <= '0;
      v1 <= 1'b0; s1 <= 1'b0; l1 <= 1'b0; o_pixel <= '0; o_valid <= 1'b0;
      o_start <= 1'b0; o_last <= 1'b0; o_frame_idx <= '0; o_done <= 1'b0;
    end else begin
      // read issued last cycle lands on i_mem_data now; register it with its markers
      o_valid <= v1;
      o_pixel <= v1 ? i_mem_data : o_pixel;
      o_start <= s1;
      o_last <= l1;
      v1 <= re;
      s1 <= re && x == '0 && y == '0;
      l1 <= re && last_x && last_y;
      o_done <= 1'b0;
      case (state)
        IDLE: if (i_go) begin
          num <= nf; x <= '0; y <= '0; addr <= '0; o_frame_idx <= '0;
          state <= nf == '0 ? DRAIN : WAIT_RDY;
        end
        WAIT_RDY: if (i_ready) state <= STREAM;
        STREAM: if (re) begin
          addr <= addr + ADDR_W'(1);
          x <= last_x ? '0 : x + XW'(1);
          if (last_x) begin
            y <= last_y ? '0 : y + YW'(1);
            if (last_y) begin
              o_frame_idx <= o_frame_idx + FC_W'(1);
              state <= more ? WAIT_RDY : DRAIN;
            end else if (LINE_GAP > 0) begin
              state <= GAP;
              gcnt <= '0;
            end
          end
        end
        GAP: begin
          gcnt <= gcnt + GW'(1);
          if (gcnt == GW'(LINE_GAP-1)) state <= STREAM;
        end
        DRAIN: if (!v1) begin
          o_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_stream_ctrl.sv
// tb_frame_stream_ctrl: directed bench with a beat scoreboard; a second instance has LINE_GAP=2.
module tb_frame_stream_ctrl;
  localparam int W = 4, H = 2, MF = 3, AW = 5, FW = 2, N = W*H;
  logic clk = 0, rst_n = 0, go = 0, go_g = 0, abort = 0, ready = 0, stall = 0;
  logic [FW-1:0] num = '0;
  logic [AW-1:0] addr, addr_g;
  logic re, re_g, valid, start, last, busy, done, valid_g, start_g, last_g, busy_g, done_g;
  logic [7:0] mdata = '0, mdata_g = '0, pix, pix_g;
  logic [FW-1:0] fidx, fidx_g;
  int cyc = 0, total = 0, passed = 0, re_cnt = 0, done_cnt = 0, bad_stall = 0;
  logic [9:0] q[$], qg[$];
  int vt[$], gt[$];

  frame_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(8), .MAX_FRAMES(MF), .LINE_GAP(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_num_frames(num), .i_abort(abort),
    .i_ready(ready), .i_stall(stall), .o_mem_addr(addr), .o_mem_re(re), .i_mem_data(mdata),
    .o_pixel(pix), .o_valid(valid), .o_start(start), .o_last(last), .o_frame_idx(fidx),
    .o_busy(busy), .o_done(done));

  frame_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(8), .MAX_FRAMES(MF), .LINE_GAP(2)) dut_g (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go_g), .i_num_frames(num), .i_abort(1'b0),
    .i_ready(1'b1), .i_stall(1'b0), .o_mem_addr(addr_g), .o_mem_re(re_g), .i_mem_data(mdata_g),
    .o_pixel(pix_g), .o_valid(valid_g), .o_start(start_g), .o_last(last_g), .o_frame_idx(fidx_g),
    .o_busy(busy_g), .o_done(done_g));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re) mdata <= 8'(addr);
    if (re_g) mdata_g <= 8'(addr_g);
  end

  task automatic chk(input string tag, input int obs, input int ex);
    total++;
    assert (obs === ex) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
  endtask

  always @(negedge clk) begin
    if (re) re_cnt++;
    if (re && stall) bad_stall++;
    if (done) done_cnt++;
    if (valid) begin
      vt.push_back(cyc);
      if (q.size() == 0) chk("unexpected_beat", int'(pix), -1);
      else chk("beat", int'({pix, start, last}), int'(q.pop_front()));
    end
    if (valid_g) begin
      gt.push_back(cyc);
      if (qg.size() == 0) chk("unexpected_beat_gap", int'(pix_g), -1);
      else chk("beat_gap", int'({pix_g, start_g, last_g}), int'(qg.pop_front()));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int n, input bit g);
    for (int i = 0; i < n; i++) begin
      if (g) qg.push_back({8'(i), i % N == 0, i % N == N-1});
      else q.push_back({8'(i), i % N == 0, i % N == N-1});
    end
  endtask

  task automatic pulse_go(input int n, input bit g);
    num = FW'(n);
    if (g) go_g = 1; else go = 1;
    step();
    go = 0;
    go_g = 0;
  endtask

  task automatic wait_done(input string tag, input bit g);
    int got = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (g ? done_g : done) begin
        got = 1;
        break;
      end
    end
    chk(tag, got, 1);
  endtask

  task automatic seek(input int a);
    int f = 0;
    for (int i = 0; i < 60; i++) begin
      if (re && addr == AW'(a)) begin
        f = 1;
        break;
      end
      step();
    end
    chk("seek_addr", f, 1);
  endtask

  initial begin
    int r0, d0;
    repeat (3) step();
    rst_n = 1;
    r0 = re_cnt;
    repeat (5) step();
    chk("rst_valid_start_last", int'({valid, start, last}), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    chk("rst_pixel", int'(pix), 0);
    chk("rst_fidx_addr", int'({fidx, addr}), 0);
    chk("idle_no_reads", re_cnt - r0, 0);
    ready = 1;
    vt.delete();
    push(N, 0);
    pulse_go(1, 0);
    wait_done("t2_done", 0);
    chk("t2_beats", vt.size(), N);
    chk("t2_consecutive", vt[N-1] - vt[0], N-1);
    chk("t2_done_latency", cyc - vt[N-1], 1);
    step();
    chk("t2_busy_after", int'(busy), 0);
    chk("t2_sb_empty", q.size(), 0);
    vt.delete();
    push(3*N, 0);
    r0 = re_cnt;
    pulse_go(3, 0);
    step();
    ready = 0;
    repeat (20) step();
    chk("t3_reads_while_not_ready", re_cnt - r0, N);
    ready = 1;
    wait_done("t3_done", 0);
    chk("t3_beats", vt.size(), 3*N);
    chk("t3_frame_idx", int'(fidx), 3);
    chk("t3_sb_empty", q.size(), 0);
    vt.delete();
    push(N, 0);
    pulse_go(1, 0);
    seek(2);
    stall = 1;
    repeat (3) step();
    stall = 0;
    wait_done("t4_done", 0);
    chk("t4_hole", vt[2] - vt[1], 4);
    chk("t4_span", vt[N-1] - vt[0], N+2);
    chk("t4_no_read_in_stall", bad_stall, 0);
    chk("t4_sb_empty", q.size(), 0);
    gt.delete();
    push(N, 1);
    pulse_go(1, 1);
    wait_done("t5_done", 1);
    chk("t5_line0", gt[3] - gt[0], 3);
    chk("t5_gap", gt[4] - gt[3], 3);
    chk("t5_line1_no_tail_gap", gt[7] - gt[4], 3);
    chk("t5_sb_empty", qg.size(), 0);
    r0 = re_cnt;
    pulse_go(0, 0);
    wait_done("num0_done", 0);
    chk("num0_no_reads", re_cnt - r0, 0);
    go = 1;
    abort = 1;
    step();
    go = 0;
    abort = 0;
    chk("go_abort_idle", int'(busy), 0);
    vt.delete();
    push(12, 0);
    d0 = done_cnt;
    pulse_go(2, 0);
    seek(13);
    abort = 1;
    step();
    abort = 0;
    chk("t6_abort_valid", int'(valid), 0);
    chk("t6_abort_busy", int'(busy), 0);
    chk("t6_abort_addr", int'(addr), 0);
    repeat (5) step();
    chk("t6_abort_no_done", done_cnt - d0, 0);
    chk("t6_abort_beats", vt.size(), 12);
    push(N, 0);
    pulse_go(1, 0);
    wait_done("t6_restart_done", 0);
    chk("t6_restart_sb_empty", q.size(), 0);
    push(12, 0);
    d0 = done_cnt;
    pulse_go(2, 0);
    seek(13);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", int'(valid), 0);
    chk("t6_rst_busy_re", int'({busy, re}), 0);
    chk("t6_rst_addr", int'(addr), 0);
    step();
    rst_n = 1;
    repeat (5) step();
    chk("t6_rst_no_done", done_cnt - d0, 0);
    chk("t6_rst_sb_empty", q.size(), 0);
    push(N, 0);
    pulse_go(1, 0);
    wait_done("t6_rst_restart_done", 0);
    chk("t6_rst_restart_sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
